if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction fetch stage of the RV32I pipeline. Sits directly upstream of the decode stage, via the IF/ID register.
- Fetches each 32-bit instruction as four byte reads from the byte-wide unified memory port, then presents the little-endian assembled word with its PC.
- Accepts redirects from decode (branch/jump) and hold requests from ctrl.

Parameters:
- ADDR_W, 32, width of PC and memory byte address.
- RESET_PC, 32'h00000000, PC loaded on reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- stall_i  in  1  ctrl hold; while 1 the held instruction is not consumed
- branch_flag_i  in  1  redirect request from decode (level, may stay high across stalls)
- branch_target_i  in  ADDR_W  redirect address
- mem_gnt_i  in  1  memory port grant; 0 = port busy, no read may issue
- mem_din_i  in  8  read byte, valid the cycle after its request
- mem_rd_o  out  1  byte read request
- mem_a_o  out  ADDR_W  byte address
- pc_o  out  ADDR_W  address of presented instruction
- inst_o  out  32  presented instruction
- inst_valid_o  out  1  pc_o/inst_o valid
- stallreq_o  out  1  fetch in progress, to ctrl

Behaviour:
- **State:** two states, FETCH and DONE.
  - Registers: pc, issue counter ic (0..4), capture counter cc (0..4), pend (byte in flight), pidx (its slot), 32-bit assembly buffer, redir_done flag.
- **Reset (rst=0, async):**
  - pc=RESET_PC, state=FETCH, ic=cc=0, pend=0, redir_done=0.
  - mem_rd_o=0, mem_a_o=RESET_PC, inst_valid_o=0, inst_o=32'h00000013, pc_o=RESET_PC.
  - stallreq_o=1 once out of reset.
- **FETCH, issue:**
  - When ic<4 and mem_gnt_i=1: mem_rd_o=1, mem_a_o=pc+ic. Then ic++, pend<=1, pidx<=ic.
  - When mem_gnt_i=0: mem_rd_o=0, ic holds, pend<=0.
- **FETCH, capture:**
  - If pend=1: buffer byte[pidx] <= mem_din_i, cc++.
  - Slot mapping: byte0 -> [7:0] … byte3 -> [31:24].
  - Capture and issue happen in the same cycle.
- **FETCH to DONE:** when the 4th byte is captured (cc becomes 4). Minimum latency: 5 cycles from FETCH entry to inst_valid_o=1.
- **DONE:**
  - inst_valid_o=1, inst_o=buffer, pc_o=pc, stallreq_o=0.
  - If stall_i=1: hold everything, no memory reads.
  - If stall_i=0: the instruction is consumed. Then pc<=pc+4, ic=cc=0, redir_done<=0, state<=FETCH.
- **In FETCH:** inst_valid_o=0, inst_o=32'h00000013, stallreq_o=1.
- **Redirect:**
  - Accepted when branch_flag_i=1 and redir_done=0, in either state.
  - Effect: pc<=branch_target_i with bit0 cleared; ic=cc=0, pend<=0, state<=FETCH, redir_done<=1.
  - Any byte returning the next cycle is discarded. The new address issues the cycle after acceptance at the earliest.
- **Priority:** reset > redirect > stall_i > consume/fetch. A redirect in DONE discards the held instruction even if stall_i=0; it is not counted as consumed.
- **Level-held redirect:** redir_done blocks repeat redirects while decode holds branch_flag_i during stalls. It clears only on a consume.
- **Arithmetic:** pc+ic and pc+4 are modulo 2^ADDR_W; wrap-around is silent.

Optional Feature:
- **Macro:** IF_PREFETCH_EN.
- **Defined:**
  - In DONE, a second buffer fetches bytes of pc+4 using the same issue/capture rules and mem_gnt_i gating.
  - On consume, buffer contents and counters transfer. If all 4 bytes are present, DONE re-enters the next cycle with pc+4; otherwise FETCH resumes at the transferred ic/cc.
  - A redirect discards the prefetch buffer.
- **Undefined:** no memory reads in DONE; the fetch of pc+4 starts only after consume.

Test Plan:
- **Reset fetch:** memory[0..3] = 13 05 a0 00, release rst, gnt=1 -> mem_a_o 0,1,2,3 on cycles 1-4; inst_valid_o=1 on cycle 5 with inst_o=32'h00a00513, pc_o=0.
- **Grant stall:** mem_gnt_i=0 for 3 cycles after byte1 issues -> mem_rd_o=0 during those cycles; valid is delayed exactly 3 cycles; inst_o unchanged.
- **Hold:** stall_i=1 for 4 cycles in DONE -> pc_o/inst_o stable, inst_valid_o=1, mem_rd_o=0 (macro off); on release pc advances to pc+4.
- **Mid-fetch redirect:** during fetch of 0xC, branch_flag_i=1, target 0x41, held 3 cycles -> returning byte discarded; next issue mem_a_o=0x40; only one redirect taken; inst at 0x40 valid 5 cycles later.
- **Redirect in DONE:** branch_flag_i=1 with stall_i=0, target 0x80 -> inst_valid_o drops next cycle; pc_o becomes 0x80, not pc+4.
- **Async reset mid-fetch:** rst low after byte2 issue -> mem_rd_o=0 and inst_valid_o=0 immediately; restart from RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: RV32I instruction fetch stage.
// Assembles each 32-bit instruction from four byte reads on a byte-wide
// memory port (little-endian) and presents it with its PC to decode.
// Optional feature macro: IF_PREFETCH_EN -- when defined, the bytes of
// pc+4 are fetched into a second buffer while an instruction is held.
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_din_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic              stallreq_o
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {FETCH, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        ic;
    logic [2:0]        cc;
    logic              pend;
    logic [1:0]        pidx;
    logic [31:0]       buff;
    logic              redir_done;
`ifdef IF_PREFETCH_EN
    logic [31:0]       pbuf;
`endif

    logic              redirect;
    logic              issue;
    logic [ADDR_W-1:0] base;
    logic [2:0]        cc_nxt;

    // Place a returned byte into its little-endian slot of a word.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  slot,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[{slot, 3'b000} +: 8] = b;
        return w;
    endfunction

    // Redirect acceptance, read issue gating and next capture count.
    always_comb begin
        redirect = branch_flag_i && !redir_done;
`ifdef IF_PREFETCH_EN
        base  = (state == DONE) ? pc + ADDR_W'(4) : pc;
        issue = rst && !redirect && mem_gnt_i && (ic < 3'd4);
`else
        base  = pc;
        issue = rst && !redirect && mem_gnt_i && (state == FETCH) && (ic < 3'd4);
`endif
        cc_nxt = cc + {2'b00, pend};
    end

    // Reads are gated by rst so the port goes quiet the instant reset asserts.
    assign mem_rd_o     = issue;
    assign mem_a_o      = base + ADDR_W'(ic);
    assign pc_o         = pc;
    assign inst_valid_o = (state == DONE);
    assign inst_o       = (state == DONE) ? buff : NOP;
    assign stallreq_o   = rst && (state == FETCH);

    // Fetch state machine: issue/capture bytes, hold, consume and redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ic         <= 3'd0;
            cc         <= 3'd0;
            pend       <= 1'b0;
            pidx       <= 2'd0;
            buff       <= NOP;
            redir_done <= 1'b0;
`ifdef IF_PREFETCH_EN
            pbuf       <= NOP;
`endif
        end else if (redirect) begin
            // A byte still in flight belongs to the old path; pend<=0 drops it.
            pc         <= {branch_target_i[ADDR_W-1:1], 1'b0};
            ic         <= 3'd0;
            cc         <= 3'd0;
            pend       <= 1'b0;
            state      <= FETCH;
            redir_done <= 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    ic   <= ic + {2'b00, issue};
                    pend <= issue;
                    pidx <= ic[1:0];
                    cc   <= cc_nxt;
                    if (pend)
                        buff <= put_byte(buff, pidx, mem_din_i);
                    if (cc_nxt == 3'd4) begin
                        // Counters restart so DONE sees a clean slate.
                        state <= DONE;
                        ic    <= 3'd0;
                        cc    <= 3'd0;
                    end
                end
                DONE: begin
`ifdef IF_PREFETCH_EN
                    ic   <= ic + {2'b00, issue};
                    pend <= issue;
                    pidx <= ic[1:0];
                    cc   <= cc_nxt;
                    if (pend)
                        pbuf <= put_byte(pbuf, pidx, mem_din_i);
                    if (!stall_i) begin
                        // Prefetched bytes and counters carry over to pc+4.
                        pc         <= pc + ADDR_W'(4);
                        redir_done <= 1'b0;
                        buff       <= pend ? put_byte(pbuf, pidx, mem_din_i) : pbuf;
                        if (cc_nxt == 3'd4) begin
                            ic <= 3'd0;
                            cc <= 3'd0;
                        end else begin
                            state <= FETCH;
                        end
                    end
`else
                    if (!stall_i) begin
                        pc         <= pc + ADDR_W'(4);
                        ic         <= 3'd0;
                        cc         <= 3'd0;
                        pend       <= 1'b0;
                        redir_done <= 1'b0;
                        state      <= FETCH;
                    end
`endif
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
